// File: rtl/uart_frame_tx_if.sv
// Control-side and UART-side handshake bundle for the frame transmitter.
// The master modport is the driver of writes/send and the UART responses.
interface uart_frame_tx_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          wr_full;
  logic [AW-1:0] wr_count;
  logic          send;
  logic [7:0]    cmd;
  logic          busy;
  logic          frame_done;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_done;
  logic          uart_tx_idle;

  modport master (
    output wr_en, wr_data, send, cmd, uart_tx_done, uart_tx_idle,
    input  wr_full, wr_count, busy, frame_done, uart_tx_data, uart_tx_start
  );

  modport slave (
    input  wr_en, wr_data, send, cmd, uart_tx_done, uart_tx_idle,
    output wr_full, wr_count, busy, frame_done, uart_tx_data, uart_tx_start
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Buffers a payload, then sends HDR0 HDR1 CMD LEN payload CHK one byte at a
// time through the UART start/done handshake.
module uart_frame_tx #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] HDR0    = 8'h55,
  parameter logic [7:0] HDR1    = 8'hAA
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_tx_if.slave bus
);
  localparam int AW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW-1:0] MAX_CNT = AW'(MAX_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [7:0]    cmd_q, cmd_d, chk_q, chk_d;
  logic [8:0]    idx_q, idx_d;
  logic [7:0]    buf_q [MAX_LEN];

  logic [8:0]    last_idx;
  logic [IW-1:0] pidx;
  logic [7:0]    cur_byte;
  logic          full, wr_ok, send_ok, is_last, in_payload, busy;

  assign full       = (cnt_q == MAX_CNT);
  assign send_ok    = (state_q == S_IDLE) && bus.send;
  // a write landing on the same edge as an accepted send is not part of the frame
  assign wr_ok      = (state_q == S_IDLE) && bus.wr_en && !bus.send && !full;
  assign last_idx   = 9'(len_q) + 9'd4;
  assign is_last    = (idx_q == last_idx);
  assign in_payload = (idx_q >= 9'd4) && (idx_q < last_idx);
  assign pidx       = IW'(idx_q - 9'd4);
  assign busy       = (state_q == S_START) || (state_q == S_WAIT);

  always_comb begin
    cur_byte = chk_q;
    if (idx_q == 9'd0)      cur_byte = HDR0;
    else if (idx_q == 9'd1) cur_byte = HDR1;
    else if (idx_q == 9'd2) cur_byte = cmd_q;
    else if (idx_q == 9'd3) cur_byte = 8'(len_q);
    else if (in_payload)    cur_byte = buf_q[pidx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (wr_ok) cnt_d = cnt_q + 1'b1;
        if (send_ok) begin
          state_d = S_START;
          cmd_d   = bus.cmd;
          len_d   = cnt_q;
          chk_d   = '0;
          idx_d   = '0;
        end
      end
      S_START: if (bus.uart_tx_idle) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.uart_tx_done) begin
          // headers and the checksum byte itself stay out of the sum
          if (idx_q >= 9'd2 && !is_last) chk_d = chk_q + cur_byte;
          if (is_last) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_ok) buf_q[cnt_q[IW-1:0]] <= bus.wr_data;
  end

  assign bus.wr_full       = full;
  assign bus.wr_count      = cnt_q;
  assign bus.busy          = busy;
  assign bus.frame_done    = (state_q == S_FIN);
  assign bus.uart_tx_start = (state_q == S_START) && bus.uart_tx_idle;
  assign bus.uart_tx_data  = busy ? cur_byte : 8'h00;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Random and directed frames against a queue-based frame model; a monitor
// pops expected bytes on every uart_tx_start.
module tb_uart_frame_tx;
  localparam int MAX_LEN = 16;
  localparam int AW = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_tx_if #(.AW(AW)) u ();

  uart_frame_tx #(.MAX_LEN(MAX_LEN), .HDR0(8'h55), .HDR1(8'hAA)) dut (
    .clk(clk),
    .rst(rst),
    .bus(u)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_fd = 0;
  int exp_fd = 0;
  int lat_max = 1;
  bit hold_idle = 0;
  bit inj_done = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame model: plain list of bytes, checksum as integer sum mod 256
  function automatic void push_frame(input logic [7:0] c);
    int sum;
    sum = int'(c) + mdl.size();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(c);
    exp_q.push_back(8'(mdl.size()));
    foreach (mdl[i]) begin
      exp_q.push_back(mdl[i]);
      sum += int'(mdl[i]);
    end
    exp_q.push_back(8'(sum % 256));
    mdl.delete();
  endfunction

  // UART model: start sampled mid-cycle, done after 1..lat_max cycles
  initial begin
    int cnt;
    bit s_start, s_rst, s_hold, s_inj;
    cnt = 0;
    u.uart_tx_done = 1'b0;
    u.uart_tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      s_start = u.uart_tx_start;
      s_rst   = rst;
      s_hold  = hold_idle;
      s_inj   = inj_done;
      @(posedge clk); #1;
      u.uart_tx_done = s_inj;
      if (!s_rst) cnt = 0;
      else begin
        if (s_start && cnt == 0) cnt = int'($urandom_range(1, lat_max));
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) u.uart_tx_done = 1'b1;
        end
      end
      u.uart_tx_idle = (cnt == 0) && !s_hold;
    end
  end

  // monitor: byte order, one start per byte, data stable start..done
  initial begin
    bit infl, stable_ok;
    logic [7:0] cur, e;
    infl = 0;
    stable_ok = 1;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) infl = 0;
      else begin
        if (u.frame_done) n_fd++;
        if (infl && u.uart_tx_data !== cur) stable_ok = 0;
        if (infl && u.uart_tx_done) begin
          check("data_stable", stable_ok, 1);
          infl = 0;
        end
        if (u.uart_tx_start) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_start: got byte %0h expected no start", u.uart_tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", u.uart_tx_data, e);
          end
          infl = 1;
          cur = u.uart_tx_data;
          stable_ok = 1;
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] d);
    @(posedge clk); #1;
    u.wr_en = 1'b1;
    u.wr_data = d;
    if (mdl.size() < MAX_LEN) mdl.push_back(d);
    @(posedge clk); #1;
    u.wr_en = 1'b0;
  endtask

  task automatic do_send(input logic [7:0] c, input bit with_wr);
    @(posedge clk); #1;
    u.send = 1'b1;
    u.cmd = c;
    if (with_wr) begin
      u.wr_en = 1'b1;
      u.wr_data = 8'hEE;
    end
    push_frame(c);
    @(posedge clk); #1;
    u.send = 1'b0;
    u.wr_en = 1'b0;
    check("busy_after_send", u.busy, 1);
  endtask

  task automatic wait_frame();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!u.frame_done && t < 3000);
    check("frame_done_seen", (t < 3000), 1);
    check("busy_at_done", u.busy, 0);
    exp_fd++;
    @(negedge clk);
    check("frame_done_count", n_fd, exp_fd);
    check("frame_done_width", u.frame_done, 0);
    check("wr_count_cleared", u.wr_count, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic count_starts(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (u.uart_tx_start) k++;
    end
  endtask

  task automatic wait_starts(input int n);
    int k, t;
    k = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (u.uart_tx_start) k++;
    end while (k < n && t < 500);
    check("start_seen", k, n);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    u.wr_en = 1'b0;
    u.wr_data = '0;
    u.send = 1'b0;
    u.cmd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy", u.busy, 0);
    check("rst_frame_done", u.frame_done, 0);
    check("rst_start", u.uart_tx_start, 0);
    check("rst_data", u.uart_tx_data, 0);
    check("rst_wr_count", u.wr_count, 0);
    check("rst_wr_full", u.wr_full, 0);

    // three-byte payload, then an empty frame
    do_write(8'h01); do_write(8'h02); do_write(8'h03);
    check("wr_count_3", u.wr_count, 3);
    do_send(8'h10, 0);
    wait_frame();
    do_send(8'h7F, 0);
    wait_frame();

    // fill past capacity; checksum wraps to 00
    for (int i = 0; i < 17; i++) begin
      do_write(8'hFF);
      if (i == 14) check("not_full_15", u.wr_full, 0);
      if (i >= 15) begin
        check("full_flag", u.wr_full, 1);
        check("full_count", u.wr_count, MAX_LEN);
      end
    end
    do_send(8'h00, 0);
    wait_frame();

    // same-cycle write dropped; idle held low; send/write while busy ignored
    do_write(8'hA1); do_write(8'hB2);
    do_send(8'h33, 1);
    check("same_cycle_wr_dropped", u.wr_count, 2);
    wait_starts(1);
    @(posedge clk); #1 hold_idle = 1'b1;
    @(posedge clk); #1;
    u.send = 1'b1; u.wr_en = 1'b1; u.wr_data = 8'h99; u.cmd = 8'h66;
    @(posedge clk); #1;
    u.send = 1'b0; u.wr_en = 1'b0;
    check("busy_wr_ignored", u.wr_count, 2);
    count_starts(50, k);
    check("hold_no_start", k, 0);
    check("hold_data_hdr1", u.uart_tx_data, 8'hAA);
    check("hold_busy", u.busy, 1);
    @(posedge clk); #1 hold_idle = 1'b0;
    @(negedge clk);
    check("hold_still_low", u.uart_tx_start, 0);
    @(negedge clk);
    check("resume_start", u.uart_tx_start, 1);
    wait_frame();
    count_starts(20, k);
    check("no_second_frame", k, 0);

    // done pulse while idle has no effect
    do_write(8'h5C);
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    @(negedge clk); @(negedge clk);
    check("idle_done_busy", u.busy, 0);
    check("idle_done_start", u.uart_tx_start, 0);
    check("idle_done_data", u.uart_tx_data, 0);
    check("idle_done_count", u.wr_count, 1);
    check("idle_done_fd", n_fd, exp_fd);
    do_send(8'h44, 0);
    wait_frame();

    // reset during payload byte 2 (sixth byte of the frame)
    lat_max = 2;
    for (int i = 0; i < 4; i++) do_write(8'($urandom));
    do_send(8'($urandom), 0);
    wait_starts(6);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    mdl.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    check("midrst_busy", u.busy, 0);
    check("midrst_count", u.wr_count, 0);
    check("midrst_start", u.uart_tx_start, 0);
    count_starts(20, k);
    check("midrst_no_start", k, 0);
    check("midrst_no_fd", n_fd, exp_fd);

    // randomized frames, some overfilled
    for (int f = 0; f < 6; f++) begin
      int len;
      len = int'($urandom_range(0, MAX_LEN + 2));
      lat_max = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) do_write(8'($urandom));
      check("rand_wr_count", u.wr_count, (len > MAX_LEN) ? MAX_LEN : len);
      do_send(8'($urandom), 0);
      wait_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Frame builder/sender on the transmit side of the switchable 2-channel UART.
- Buffers a payload written by the control logic, then serialises one complete frame through the UART byte handshake (tx_data/tx_start/tx_done/tx_idle): header, command, length, payload, checksum.
- Sits between the DDS control/status logic and the UART transmitter. Baud selection stays inside the UART.

Parameters:
- MAX_LEN, 16, payload buffer depth in bytes (1..255); AW = clog2(MAX_LEN+1) is the count width.
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- wr_en  in  1  payload byte write strobe
- wr_data  in  8  payload byte
- wr_full  out  1  buffer holds MAX_LEN bytes
- wr_count  out  AW  bytes currently buffered
- send  in  1  one-cycle request to transmit a frame
- cmd  in  8  command byte, sampled on the cycle send is accepted
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last byte's tx_done
- uart_tx_data  out  8  byte to UART, stable from uart_tx_start until uart_tx_done
- uart_tx_start  out  1  one-cycle start pulse to UART
- uart_tx_done  in  1  UART byte-complete pulse
- uart_tx_idle  in  1  UART ready to accept a byte

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-low: sampled low at a clk edge, it resets everything.
- Reset values: busy=0, frame_done=0, uart_tx_start=0, uart_tx_data=8'h00, wr_count=0, wr_full=0, FSM=IDLE, checksum=0.
- Frame format, in order: HDR0, HDR1, CMD, LEN, payload[0..LEN-1], CHK.
  - LEN = wr_count at send acceptance.
  - CHK = (CMD + LEN + sum of payload) mod 256. Use an 8-bit accumulator with wrap-around.
- Buffer writes:
  - Accepted only in IDLE with wr_count<MAX_LEN. Each write stores at index wr_count and increments the count.
  - wr_en when full or busy is ignored silently; count is unchanged.
- send acceptance:
  - Accepted only in IDLE.
  - A wr_en in the same cycle as an accepted send is ignored and is not part of the frame.
  - send while busy is ignored. No queuing.
- FSM states:
  - IDLE: on accepted send, latch cmd and LEN, clear checksum, set byte index 0, go to START.
  - START: present the byte for the current index on uart_tx_data. If uart_tx_idle=1, pulse uart_tx_start for exactly 1 cycle and go to WAIT. Otherwise hold in START with start low; there is no timeout.
  - WAIT: hold uart_tx_data. On uart_tx_done, add the byte to the checksum if it is CMD, LEN or payload. If that was the CHK byte go to FIN, else increment the index and go to START.
  - FIN: pulse frame_done for 1 cycle, clear wr_count to 0, go to IDLE.
- Timing:
  - send accepted at edge N: busy=1 from N+1.
  - The first uart_tx_start is asserted in the cycle after entering START, provided uart_tx_idle=1.
  - tx_done at cycle D: next start at D+1 (the cycle START is entered), if idle.
  - frame_done and busy=0 one cycle after the final tx_done.
- uart_tx_done outside WAIT is ignored.
- LEN=0 is legal: a 5-byte frame with CHK=CMD.
- Reset mid-frame: FSM aborts to IDLE and the buffer is cleared. A byte already inside the UART is not recalled; the UART shares the same reset.

Test Plan:
- Write 01,02,03; send with cmd=10 -> UART bytes 55 AA 10 03 01 02 03 19. frame_done pulses once. wr_count=0 afterwards.
- No writes; send with cmd=7F -> bytes 55 AA 7F 00 7F.
- Write 17 bytes of FF -> wr_full=1 after the 16th and wr_count=16. Send with cmd=00 -> LEN 10, 16×FF, CHK 00 (wrap-around).
- Mid-frame: pulse send and wr_en -> no second frame and wr_count unchanged. Hold uart_tx_idle=0 for 50 cycles -> uart_tx_start stays 0 and resumes the cycle after idle rises.
- Pulse uart_tx_done in IDLE -> no output change. One-cycle-latency UART model -> exactly one start per byte, each data byte stable from start to done.
- Assert rst low during payload byte 2 -> busy=0, wr_count=0, no further starts. A new frame afterwards is correct.
